// File: rtl/ntt_pkg.sv
// Shared types and defaults for the NTT address sequencer.
package ntt_pkg;

  localparam int LOG_N_DEF      = 9;
  localparam int PIPE_DEPTH_DEF = 8;
  localparam int ADDR_W         = LOG_N_DEF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Read-address pair as carried down the butterfly pipe, hi word first.
  typedef struct packed {
    logic [ADDR_W-1:0] hi;
    logic [ADDR_W-1:0] lo;
  } addr_pair_t;

endpackage

// File: rtl/ntt_bfly_addr.sv
// Combinational butterfly map: (b, s) -> (addr_lo, addr_hi, tw_idx).
// addr_lo is b with a zero inserted at bit s, addr_hi sets that bit,
// tw_idx is the low s bits of b left-aligned in the twiddle index.
module ntt_bfly_addr #(
  parameter int LOG_N = 9,
  localparam int SW   = $clog2(LOG_N)
) (
  input  logic [LOG_N-2:0] b,
  input  logic [SW-1:0]    s,
  output logic [LOG_N-1:0] addr_lo,
  output logic [LOG_N-1:0] addr_hi,
  output logic [LOG_N-2:0] tw_idx
);

  localparam logic [LOG_N-1:0] ONE   = LOG_N'(1);
  localparam logic [SW-1:0]    TOP_S = SW'(LOG_N - 1);

  logic [LOG_N-1:0] bext;
  logic [LOG_N-1:0] mask;

  assign bext = {1'b0, b};

  // Split b at bit s: low part stays, high part moves up one position.
  always_comb begin
    mask    = (ONE << s) - ONE;
    addr_lo = (bext & mask) | ((bext & ~mask) << 1);
    addr_hi = addr_lo | (ONE << s);
    tw_idx  = (b & mask[LOG_N-2:0]) << (TOP_S - s);
  end

endmodule

// File: rtl/ntt_addr_gen.sv
// Butterfly address sequencer for the in-place radix-2 NTT.
// Walks every stage, issuing one butterfly per enabled cycle, then idles
// PIPE_DEPTH enabled cycles so the stage is fully written back before the
// next stage reads it.
// Optional build macro NTT_ADDR_GEN_INV_EN adds the inv input, which runs
// the stages in descending order for the inverse transform.
import ntt_pkg::*;

module ntt_addr_gen #(
  parameter int LOG_N      = LOG_N_DEF,
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clken,
  input  logic                     start,
`ifdef NTT_ADDR_GEN_INV_EN
  input  logic                     inv,
`endif
  output logic [2*LOG_N-1:0]       addr_pair,
  output logic [LOG_N-2:0]         tw_idx,
  output logic                     valid,
  output logic [$clog2(LOG_N)-1:0] stage,
  output logic                     busy,
  output logic                     done
);

  localparam int SW = $clog2(LOG_N);
  localparam int DW = $clog2(PIPE_DEPTH + 1);
  localparam int BW = LOG_N - 1;

  localparam logic [BW-1:0] B_LAST = '1;
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_DEPTH - 1);
  localparam logic [SW-1:0] S_TOP  = SW'(LOG_N - 1);

  state_e          state;
  logic [BW-1:0]   b;
  logic [DW-1:0]   dcnt;
  logic            inv_r;
  logic            inv_in;

  logic [SW-1:0]   s_first;
  logic [SW-1:0]   s_last;
  logic [SW-1:0]   s_step;
  logic [BW-1:0]   bf_b;
  logic [SW-1:0]   bf_s;
  logic [LOG_N-1:0] bf_lo;
  logic [LOG_N-1:0] bf_hi;
  logic [BW-1:0]   bf_tw;

`ifdef NTT_ADDR_GEN_INV_EN
  assign inv_in = inv;
`else
  assign inv_in = 1'b0;
`endif

  assign s_first = inv_in ? S_TOP : '0;
  assign s_last  = inv_r  ? '0    : S_TOP;
  assign s_step  = inv_r  ? stage - 1'b1 : stage + 1'b1;

  // Outputs are registered, so the map is fed the butterfly that will be
  // on the outputs next cycle: b+1 while running, b=0 of the upcoming
  // stage when leaving IDLE or DRAIN.
  assign bf_b = (state == RUN) ? b + 1'b1 : '0;
  assign bf_s = (state == RUN)   ? stage :
                (state == DRAIN) ? s_step : s_first;

  ntt_bfly_addr #(.LOG_N(LOG_N)) u_bfly (
    .b       (bf_b),
    .s       (bf_s),
    .addr_lo (bf_lo),
    .addr_hi (bf_hi),
    .tw_idx  (bf_tw)
  );

  // Sequencer FSM; b and stage name the butterfly currently on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      stage     <= '0;
      b         <= '0;
      dcnt      <= '0;
      inv_r     <= 1'b0;
      addr_pair <= '0;
      tw_idx    <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (clken) begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          valid <= 1'b0;
          if (start) begin
            state     <= RUN;
            inv_r     <= inv_in;
            stage     <= s_first;
            b         <= '0;
            busy      <= 1'b1;
            valid     <= 1'b1;
            addr_pair <= {bf_hi, bf_lo};
            tw_idx    <= bf_tw;
          end
        end
        RUN: begin
          if (b == B_LAST) begin
            b     <= '0;
            dcnt  <= '0;
            valid <= 1'b0;
            state <= DRAIN;
          end else begin
            b         <= b + 1'b1;
            valid     <= 1'b1;
            addr_pair <= {bf_hi, bf_lo};
            tw_idx    <= bf_tw;
          end
        end
        DRAIN: begin
          if (dcnt == D_LAST) begin
            if (stage == s_last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= RUN;
              stage     <= s_step;
              b         <= '0;
              valid     <= 1'b1;
              addr_pair <= {bf_hi, bf_lo};
              tw_idx    <= bf_tw;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Directed bench for ntt_addr_gen: butterfly-map vector table plus
// full-run, stalled-run, mid-run start/reset and (optionally) inverse runs.
module tb_ntt_addr_gen;
  import ntt_pkg::*;

  localparam int LOG_N = 9;
  localparam int N     = 512;
  localparam int PD    = 8;
  localparam int PER   = N / 2 + PD;
  localparam int TOTAL = 1 + LOG_N * PER;

  logic        clk = 1'b0;
  logic        rst, clken, start;
`ifdef NTT_ADDR_GEN_INV_EN
  logic        inv;
`endif
  logic [17:0] addr_pair;
  logic [7:0]  tw_idx;
  logic        valid;
  logic [3:0]  stage;
  logic        busy, done;

  always #5 clk = ~clk;

  ntt_addr_gen #(.LOG_N(LOG_N), .PIPE_DEPTH(PD)) dut (
    .clk       (clk),
    .rst       (rst),
    .clken     (clken),
    .start     (start),
`ifdef NTT_ADDR_GEN_INV_EN
    .inv       (inv),
`endif
    .addr_pair (addr_pair),
    .tw_idx    (tw_idx),
    .valid     (valid),
    .stage     (stage),
    .busy      (busy),
    .done      (done)
  );

  logic [7:0] t_b;
  logic [3:0] t_s;
  logic [8:0] t_lo, t_hi;
  logic [7:0] t_tw;

  ntt_bfly_addr #(.LOG_N(LOG_N)) u_bf (
    .b(t_b), .s(t_s), .addr_lo(t_lo), .addr_hi(t_hi), .tw_idx(t_tw)
  );

  typedef struct {
    logic [7:0] b;
    logic [3:0] s;
    logic [8:0] lo;
    logic [8:0] hi;
    logic [7:0] tw;
  } bvec_t;

  int tests = 0;
  int fails = 0;
  int hits[LOG_N][N];
  int nvalid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected {valid,busy,done,stage,hi,lo,tw} at enabled cycle c after start.
  function automatic logic [32:0] exp_vec(input int c, input bit iv);
    int k, st, pos, s, b, lo, hi, tw, stg;
    bit v, bz, dn;
    k = c - 1; st = k / PER; pos = k % PER;
    lo = 0; hi = 0; tw = 0;
    if (c >= TOTAL) begin
      v = 0; bz = 0; dn = (c == TOTAL); stg = iv ? 0 : LOG_N - 1;
    end else begin
      s = iv ? LOG_N - 1 - st : st;
      v = (pos < N / 2); b = pos; bz = 1; dn = 0; stg = s;
      if (v) begin
        lo = ((b >> s) << (s + 1)) | (b & ((1 << s) - 1));
        hi = lo | (1 << s);
        tw = (b & ((1 << s) - 1)) << (LOG_N - 1 - s);
      end
    end
    return {v, bz, dn, 4'(stg), 9'(hi), 9'(lo), 8'(tw)};
  endfunction

  function automatic logic [32:0] act_vec(input bit ev);
    return {valid, busy, done, stage, ev ? addr_pair : 18'd0, ev ? tw_idx : 8'd0};
  endfunction

  function automatic logic [32:0] raw_vec();
    return {valid, busy, done, stage, addr_pair, tw_idx};
  endfunction

  task automatic record(input int e);
    int st;
    st = (e - 1) / PER;
    if (valid && st < LOG_N) begin
      nvalid++;
      hits[st][addr_pair[8:0]]++;
      hits[st][addr_pair[17:9]]++;
    end
  endtask

  // Start a transform and follow it for max_c enabled cycles.
  task automatic run_trace(input bit iv, input int stall, input int max_c,
                           input bit poke, input bit cov);
    int e, cyc, bad;
    bit ce;
    logic [32:0] ev, prev;
    foreach (hits[i, j]) hits[i][j] = 0;
    nvalid = 0;
    clken = 1'b1; start = 1'b1;
`ifdef NTT_ADDR_GEN_INV_EN
    inv = iv;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    e = 1; cyc = 0;
    ev = exp_vec(e, iv);
    chk($sformatf("trace c%0d", e), 64'(act_vec(ev[32])), 64'(ev));
    if (cov) record(e);
    prev = raw_vec();
    while (e < max_c && cyc < 20000) begin
      ce = (stall == 0) || ($urandom_range(0, 99) >= stall);
      clken = ce;
      start = poke && (e == 100);
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (ce) begin
        e++;
        ev = exp_vec(e, iv);
        chk($sformatf("trace c%0d", e), 64'(act_vec(ev[32])), 64'(ev));
        if (cov) record(e);
      end else begin
        chk($sformatf("hold c%0d", e), 64'(raw_vec()), 64'(prev));
      end
      prev = raw_vec();
    end
    clken = 1'b1;
    if (e < max_c) chk("cycle_budget", e, max_c);
    if (cov) begin
      chk("valid_count", nvalid, (N / 2) * LOG_N);
      for (int s = 0; s < LOG_N; s++) begin
        bad = 0;
        for (int a = 0; a < N; a++) if (hits[s][a] != 1) bad++;
        chk($sformatf("cover_stage%0d", s), bad, 0);
      end
    end
  endtask

  task automatic step_idle_check(input string name);
    @(posedge clk); #1;
    chk(name, {valid, busy, done}, 3'b000);
  endtask

  initial begin
    bvec_t      vecs[9];
    addr_pair_t p;
    logic [32:0] ev;

    vecs[0] = '{8'd5,   4'd0, 9'd10,  9'd11,  8'd0};
    vecs[1] = '{8'd13,  4'd3, 9'd21,  9'd29,  8'd160};
    vecs[2] = '{8'd255, 4'd8, 9'd255, 9'd511, 8'd255};
    vecs[3] = '{8'd0,   4'd0, 9'd0,   9'd1,   8'd0};
    vecs[4] = '{8'd255, 4'd0, 9'd510, 9'd511, 8'd0};
    vecs[5] = '{8'd0,   4'd8, 9'd0,   9'd256, 8'd0};
    vecs[6] = '{8'd1,   4'd1, 9'd1,   9'd3,   8'd128};
    vecs[7] = '{8'd100, 4'd4, 9'd196, 9'd212, 8'd64};
    vecs[8] = '{8'd170, 4'd7, 9'd298, 9'd426, 8'd84};

    rst = 1'b1; clken = 1'b0; start = 1'b0;
`ifdef NTT_ADDR_GEN_INV_EN
    inv = 1'b0;
`endif
    t_b = '0; t_s = '0;
    #12;
    chk("reset_state", 64'(raw_vec()), 64'd0);
    rst = 1'b0;

    // Butterfly map vectors.
    foreach (vecs[i]) begin
      t_b = vecs[i].b; t_s = vecs[i].s;
      #1;
      p.hi = vecs[i].hi; p.lo = vecs[i].lo;
      chk($sformatf("bfly b%0d s%0d", vecs[i].b, vecs[i].s), {t_hi, t_lo, t_tw}, {p, vecs[i].tw});
    end

    // Full forward run, no stalls.
    run_trace(1'b0, 0, TOTAL, 1'b0, 1'b1);
    step_idle_check("idle_after_done");

    // Same run with random clken gaps.
    run_trace(1'b0, 30, TOTAL, 1'b0, 1'b0);
    step_idle_check("idle_after_stall_run");

    // start pulsed mid-run is ignored; async reset at cycle 500.
    run_trace(1'b0, 0, 499, 1'b1, 1'b0);
    @(posedge clk); #1;
    ev = exp_vec(500, 1'b0);
    chk("trace c500", 64'(act_vec(ev[32])), 64'(ev));
    #2 rst = 1'b1;
    #1 chk("async_rst", 64'(raw_vec()), 64'd0);
    start = 1'b1;
    @(posedge clk); #1;
    chk("rst_over_start", {valid, busy}, 2'b00);
    rst = 1'b0; start = 1'b0;
    step_idle_check("idle_after_rst");

    // Restart after reset begins again at stage 0, b=0.
    run_trace(1'b0, 0, 300, 1'b0, 1'b0);
    rst = 1'b1; #1; rst = 1'b0;
    step_idle_check("idle_after_rst2");

`ifdef NTT_ADDR_GEN_INV_EN
    // Inverse ordering: stages 8 down to 0.
    run_trace(1'b1, 0, TOTAL, 1'b0, 1'b1);
    step_idle_check("idle_after_inv");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
